// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: EX/MEM destination tracking, operand-forward selects and load-use stall
//   clk_i, rst_i                      clock, synchronous active-high reset
//   id_valid_i, id_rs_i, id_rt_i      ID instruction and its source registers
//   id_rs_used_i, id_rt_used_i        which sources the ID instruction reads
//   id_rd_i, id_regwrite_i            ID destination and register-file write enable
//   id_memread_i, flush_i             ID is a load; squash ID (branch taken)
//   forward_a_o, forward_b_o          registered EX operand selects (00 RF, 01 EX/MEM, 10 MEM/WB)
//   stall_o, stall_cnt_o              load-use stall and saturating stall-cycle counter
module forward_hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  id_rs_used_i,
   input  logic                  id_rt_used_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_regwrite_i,
   input  logic                  id_memread_i,
   input  logic                  flush_i,
   output logic [1:0]            forward_a_o,
   output logic [1:0]            forward_b_o,
   output logic                  stall_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);
   logic                  r_ex_valid, r_ex_regwrite, r_ex_memread;
   logic [REG_ADDR_W-1:0] r_ex_rd;
   logic                  r_mem_valid, r_mem_regwrite;
   logic [REG_ADDR_W-1:0] r_mem_rd;
   logic                  w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_issue;
   logic [1:0]            w_fwd_a, w_fwd_b;
   // a stage hits a source only if that source is actually read and is not $0
   always_comb begin
      w_ex_rs  = id_rs_used_i && id_rs_i != '0 && r_ex_valid && r_ex_regwrite && r_ex_rd == id_rs_i;
      w_ex_rt  = id_rt_used_i && id_rt_i != '0 && r_ex_valid && r_ex_regwrite && r_ex_rd == id_rt_i;
      w_mem_rs = id_rs_used_i && id_rs_i != '0 && r_mem_valid && r_mem_regwrite && r_mem_rd == id_rs_i;
      w_mem_rt = id_rt_used_i && id_rt_i != '0 && r_mem_valid && r_mem_regwrite && r_mem_rd == id_rt_i;
      stall_o  = id_valid_i && !flush_i && r_ex_memread && (w_ex_rs || w_ex_rt);
      w_issue  = id_valid_i && !stall_o && !flush_i;
      // youngest producer (EX) wins over MEM; bubbles always select the register file
      w_fwd_a  = !w_issue ? 2'b00 : w_ex_rs ? 2'b01 : w_mem_rs ? 2'b10 : 2'b00;
      w_fwd_b  = !w_issue ? 2'b00 : w_ex_rt ? 2'b01 : w_mem_rt ? 2'b10 : 2'b00;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ex_valid     <= 1'b0;
         r_ex_regwrite  <= 1'b0;
         r_ex_memread   <= 1'b0;
         r_ex_rd        <= '0;
         r_mem_valid    <= 1'b0;
         r_mem_regwrite <= 1'b0;
         r_mem_rd       <= '0;
         forward_a_o    <= 2'b00;
         forward_b_o    <= 2'b00;
         stall_cnt_o    <= '0;
      end else begin
         r_mem_valid    <= r_ex_valid;
         r_mem_regwrite <= r_ex_regwrite;
         r_mem_rd       <= r_ex_rd;
         r_ex_valid     <= w_issue;
         r_ex_regwrite  <= w_issue && id_regwrite_i;
         r_ex_memread   <= w_issue && id_memread_i;
         r_ex_rd        <= w_issue ? id_rd_i : '0;
         forward_a_o    <= w_fwd_a;
         forward_b_o    <= w_fwd_b;
         if (stall_o && !(&stall_cnt_o))
            stall_cnt_o <= stall_cnt_o + 1'b1;
      end
   end
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: directed and randomized checks of forward_hazard_unit against a record-level model
module tb_forward_hazard_unit;
   typedef struct packed {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       rsu;
      logic       rtu;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } ins_t;
   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } rec_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        id_valid_i = 1'b0, id_rs_used_i = 1'b0, id_rt_used_i = 1'b0;
   logic        id_regwrite_i = 1'b0, id_memread_i = 1'b0, flush_i = 1'b0;
   logic [4:0]  id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
   logic [1:0]  forward_a_o, forward_b_o, fa2, fb2;
   logic        stall_o, stall2;
   logic [15:0] stall_cnt_o;
   logic [1:0]  cnt2;

   int   n_cmp = 0, n_err = 0;
   rec_t ex = '0, mem = '0;
   logic [1:0]  ea = 2'b00, eb = 2'b00;
   logic [15:0] ecnt = '0;
   logic [1:0]  ecnt2 = '0;
   logic        last_stall;

   always #5 clk_i = ~clk_i;

   forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
      .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i), .id_rd_i(id_rd_i),
      .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .flush_i(flush_i),
      .forward_a_o(forward_a_o), .forward_b_o(forward_b_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o));

   forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut2 (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
      .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i), .id_rd_i(id_rd_i),
      .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .flush_i(flush_i),
      .forward_a_o(fa2), .forward_b_o(fb2), .stall_o(stall2), .stall_cnt_o(cnt2));

   function automatic logic writes(input rec_t s, input logic [4:0] r);
      return s.v && s.rw && s.rd == r && r != 5'd0;
   endfunction

   function automatic ins_t mk(input logic [4:0] rd, input logic rw, input logic mr,
                               input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu);
      ins_t i;
      i = '{v: 1'b1, rs: rs, rt: rt, rsu: rsu, rtu: rtu, rd: rd, rw: rw, mr: mr};
      return i;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // one pipeline cycle: drive ID, check the combinational stall, clock, check registered outputs
   task automatic cyc(input ins_t i, input logic fl, input logic rs_t);
      logic       ms, iss;
      logic [1:0] na, nb;
      id_valid_i = i.v; id_rs_i = i.rs; id_rt_i = i.rt; id_rs_used_i = i.rsu; id_rt_used_i = i.rtu;
      id_rd_i = i.rd; id_regwrite_i = i.rw; id_memread_i = i.mr; flush_i = fl; rst_i = rs_t;
      #1;
      ms = i.v && !fl && ex.mr && ((i.rsu && writes(ex, i.rs)) || (i.rtu && writes(ex, i.rt)));
      iss = i.v && !ms && !fl;
      na = !iss ? 2'b00 : (i.rsu && writes(ex, i.rs)) ? 2'b01 : (i.rsu && writes(mem, i.rs)) ? 2'b10 : 2'b00;
      nb = !iss ? 2'b00 : (i.rtu && writes(ex, i.rt)) ? 2'b01 : (i.rtu && writes(mem, i.rt)) ? 2'b10 : 2'b00;
      last_stall = stall_o;
      chk("stall", {31'd0, stall_o}, {31'd0, ms});
      chk("stall_w2", {31'd0, stall2}, {31'd0, ms});
      @(posedge clk_i);
      if (rs_t) begin
         ex = '0; mem = '0; ea = 2'b00; eb = 2'b00; ecnt = '0; ecnt2 = '0;
      end else begin
         mem = ex;
         ex = iss ? rec_t'{v: 1'b1, rd: i.rd, rw: i.rw, mr: i.mr} : rec_t'(0);
         ea = na; eb = nb;
         if (ms && ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
         if (ms && ecnt2 != 2'd3) ecnt2 = ecnt2 + 2'd1;
      end
      #1;
      chk("fwd_a", {30'd0, forward_a_o}, {30'd0, ea});
      chk("fwd_b", {30'd0, forward_b_o}, {30'd0, eb});
      chk("stall_cnt", {16'd0, stall_cnt_o}, {16'd0, ecnt});
      chk("stall_cnt_w2", {30'd0, cnt2}, {30'd0, ecnt2});
      chk("fwd_a_w2", {30'd0, fa2}, {30'd0, ea});
   endtask

   ins_t nop, add3, sub5, add3b, or6, unrel, lw2, use2, lw0, use0, r;

   initial begin
      nop   = '0;
      add3  = mk(5'd3, 1, 0, 5'd1, 1, 5'd2, 1);
      sub5  = mk(5'd5, 1, 0, 5'd3, 1, 5'd4, 1);
      add3b = mk(5'd3, 1, 0, 5'd1, 1, 5'd1, 1);
      or6   = mk(5'd6, 1, 0, 5'd3, 1, 5'd3, 1);
      unrel = mk(5'd9, 1, 0, 5'd10, 1, 5'd11, 1);
      lw2   = mk(5'd2, 1, 1, 5'd1, 1, 5'd0, 0);
      use2  = mk(5'd7, 1, 0, 5'd2, 1, 5'd1, 1);
      lw0   = mk(5'd0, 1, 1, 5'd1, 1, 5'd0, 0);
      use0  = mk(5'd7, 1, 0, 5'd0, 1, 5'd0, 1);
      cyc(nop, 0, 1);
      chk("rst_fa", {30'd0, forward_a_o}, 32'd0);
      chk("rst_cnt", {16'd0, stall_cnt_o}, 32'd0);
      cyc(add3, 0, 0); cyc(sub5, 0, 0);
      chk("b2b_fa", {30'd0, forward_a_o}, 32'd1);
      chk("b2b_fb", {30'd0, forward_b_o}, 32'd0);
      chk("b2b_stall", {31'd0, last_stall}, 32'd0);
      cyc(add3, 0, 0); cyc(add3b, 0, 0); cyc(or6, 0, 0);
      chk("prio_fa", {30'd0, forward_a_o}, 32'd1);
      chk("prio_fb", {30'd0, forward_b_o}, 32'd1);
      cyc(add3, 0, 0); cyc(unrel, 0, 0); cyc(or6, 0, 0);
      chk("dist2_fa", {30'd0, forward_a_o}, 32'd2);
      chk("dist2_fb", {30'd0, forward_b_o}, 32'd2);
      cyc(lw2, 0, 0); cyc(use2, 0, 0);
      chk("lu_stall", {31'd0, last_stall}, 32'd1);
      chk("lu_bubble_fa", {30'd0, forward_a_o}, 32'd0);
      chk("lu_cnt", {16'd0, stall_cnt_o}, 32'd1);
      cyc(use2, 0, 0);
      chk("lu_release", {31'd0, last_stall}, 32'd0);
      chk("lu_fa", {30'd0, forward_a_o}, 32'd2);
      chk("lu_fb", {30'd0, forward_b_o}, 32'd0);
      cyc(lw0, 0, 0); cyc(use0, 0, 0);
      chk("r0_stall", {31'd0, last_stall}, 32'd0);
      chk("r0_fa", {30'd0, forward_a_o}, 32'd0);
      chk("r0_fb", {30'd0, forward_b_o}, 32'd0);
      cyc(lw2, 0, 0); cyc(use2, 1, 0);
      chk("fl_stall", {31'd0, last_stall}, 32'd0);
      chk("fl_cnt", {16'd0, stall_cnt_o}, 32'd1);
      chk("fl_fa", {30'd0, forward_a_o}, 32'd0);
      cyc(nop, 0, 0);
      for (int k = 0; k < 4; k++) begin
         cyc(lw2, 0, 0); cyc(use2, 0, 0); cyc(use2, 0, 0);
      end
      chk("sat_cnt2", {30'd0, cnt2}, 32'd3);
      chk("cnt16", {16'd0, stall_cnt_o}, 32'd5);
      cyc(lw2, 0, 0); cyc(use2, 0, 1);
      cyc(use2, 0, 0);
      chk("rst_mid_stall", {31'd0, last_stall}, 32'd0);
      chk("rst_mid_fa", {30'd0, forward_a_o}, 32'd0);
      chk("rst_mid_cnt", {16'd0, stall_cnt_o}, 32'd0);
      chk("rst_mid_cnt2", {30'd0, cnt2}, 32'd0);
      for (int k = 0; k < 3000; k++) begin
         r.v   = ($urandom_range(0, 9) != 0);
         r.rs  = 5'($urandom_range(0, 3));
         r.rt  = ($urandom_range(0, 3) == 0) ? r.rs : 5'($urandom_range(0, 3));
         r.rsu = ($urandom_range(0, 4) != 0);
         r.rtu = ($urandom_range(0, 1) != 0);
         r.rd  = 5'($urandom_range(0, 3));
         r.rw  = ($urandom_range(0, 4) != 0);
         r.mr  = ($urandom_range(0, 2) == 0);
         cyc(r, $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
